// File: rtl/sensor_pkg.sv
// Shared definitions for the irrigation sensor conditioning stage:
// level-fault FSM encodings, sensor bit indices and the level validity rule.
package sensor_pkg;

   typedef enum logic [1:0] {
      FLT_OK      = 2'd0,
      FLT_SUSPECT = 2'd1,
      FLT_FAULT   = 2'd2,
      FLT_RECOVER = 2'd3
   } fault_state_e;

   localparam int unsigned IDX_H     = 0;
   localparam int unsigned IDX_M     = 1;
   localparam int unsigned IDX_L     = 2;
   localparam int unsigned IDX_US    = 3;
   localparam int unsigned IDX_UA    = 4;
   localparam int unsigned IDX_T     = 5;
   localparam int unsigned N_SENSORS = 6;

   // A float switch above must never be wet while one below it is dry; 000 is a legal empty tank.
   function automatic logic level_invalid(input logic h, input logic m, input logic l);
      return (h & ~m) | (h & ~l) | (m & ~l);
   endfunction

endpackage

// File: rtl/debounce_bit.sv
// One sensor channel: 2-FF synchroniser followed by a tick-counted debounce filter.
// dout follows the synchronised input only after it has differed for DEBOUNCE_TICKS ticks.
module debounce_bit #(
   parameter int unsigned DEBOUNCE_TICKS = 20
) (
   input  logic clock,
   input  logic Rst,
   input  logic tick,
   input  logic din_async,
   output logic dout,
   output logic upd
);

   localparam int unsigned CW = $clog2(DEBOUNCE_TICKS + 1);

   logic          s1_q;
   logic          s2_q;
   logic          dout_q;
   logic          dout_d;
   logic          upd_q;
   logic          upd_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_ff @(posedge clock) begin
      if (Rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= din_async;
         s2_q <= s1_q;
      end
   end

   // Any cycle where the input agrees with the output wipes the count, so short glitches never add up.
   always_comb begin
      cnt_d  = cnt_q;
      dout_d = dout_q;
      upd_d  = 1'b0;
      if (s2_q == dout_q) begin
         cnt_d = '0;
      end else if (tick) begin
         if (cnt_q == CW'(DEBOUNCE_TICKS - 1)) begin
            dout_d = s2_q;
            cnt_d  = '0;
            upd_d  = 1'b1;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (Rst) begin
         cnt_q  <= '0;
         dout_q <= 1'b0;
         upd_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         dout_q <= dout_d;
         upd_q  <= upd_d;
      end
   end

   assign dout = dout_q;
   assign upd  = upd_q;

endmodule

// File: rtl/sensor_conditioner.sv
// Input conditioning for the irrigation controller: debounced level/humidity/temperature bits,
// a shared debounce tick, a change strobe and a filtered level-inconsistency fault.
module sensor_conditioner
   import sensor_pkg::*;
#(
   parameter int unsigned TICK_DIV       = 50000,
   parameter int unsigned DEBOUNCE_TICKS = 20,
   parameter int unsigned FAULT_TICKS    = 100
) (
   input  logic clock,
   input  logic Rst,
   input  logic H_raw,
   input  logic M_raw,
   input  logic L_raw,
   input  logic Us_raw,
   input  logic Ua_raw,
   input  logic T_raw,
   output logic H,
   output logic M,
   output logic L,
   output logic Us,
   output logic Ua,
   output logic T,
   output logic tick,
   output logic changed,
   output logic level_fault
);

   localparam int unsigned TW = $clog2(TICK_DIV);
   localparam int unsigned FW = $clog2(FAULT_TICKS + 1);

   logic [TW-1:0]          tick_cnt_q;
   logic [TW-1:0]          tick_cnt_d;
   logic                   tick_q;
   logic [N_SENSORS-1:0]   raw_c;
   logic [N_SENSORS-1:0]   dout_c;
   logic [N_SENSORS-1:0]   upd_c;
   logic                   changed_q;
   logic                   invalid_c;
   fault_state_e           state_q;
   logic [FW-1:0]          fcnt_q;
   logic                   level_fault_q;

   // Tick is registered alongside the counter so it is high exactly while the count reads TICK_DIV-1.
   always_comb begin
      tick_cnt_d = tick_cnt_q + TW'(1);
      if (tick_cnt_q == TW'(TICK_DIV - 1)) begin
         tick_cnt_d = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (Rst) begin
         tick_cnt_q <= '0;
         tick_q     <= 1'b0;
      end else begin
         tick_cnt_q <= tick_cnt_d;
         tick_q     <= (tick_cnt_d == TW'(TICK_DIV - 1));
      end
   end

   assign raw_c[IDX_H]  = H_raw;
   assign raw_c[IDX_M]  = M_raw;
   assign raw_c[IDX_L]  = L_raw;
   assign raw_c[IDX_US] = Us_raw;
   assign raw_c[IDX_UA] = Ua_raw;
   assign raw_c[IDX_T]  = T_raw;

   for (genvar g = 0; g < int'(N_SENSORS); g++) begin : g_db
      debounce_bit #(
         .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
      ) u_debounce_bit (
         .clock     (clock),
         .Rst       (Rst),
         .tick      (tick_q),
         .din_async (raw_c[g]),
         .dout      (dout_c[g]),
         .upd       (upd_c[g])
      );
   end

   always_ff @(posedge clock) begin
      if (Rst) begin
         changed_q <= 1'b0;
      end else begin
         changed_q <= |upd_c;
      end
   end

   assign invalid_c = level_invalid(dout_c[IDX_H], dout_c[IDX_M], dout_c[IDX_L]);

   // Level supervision: a validity change always restarts the filter, ticks only count persistence.
   always_ff @(posedge clock) begin
      if (Rst) begin
         state_q       <= FLT_OK;
         fcnt_q        <= '0;
         level_fault_q <= 1'b0;
      end else begin
         case (state_q)
            FLT_OK: begin
               if (invalid_c) begin
                  state_q <= FLT_SUSPECT;
                  fcnt_q  <= '0;
               end
            end
            FLT_SUSPECT: begin
               if (!invalid_c) begin
                  state_q <= FLT_OK;
                  fcnt_q  <= '0;
               end else if (tick_q) begin
                  if (fcnt_q == FW'(FAULT_TICKS - 1)) begin
                     state_q       <= FLT_FAULT;
                     fcnt_q        <= '0;
                     level_fault_q <= 1'b1;
                  end else begin
                     fcnt_q <= fcnt_q + FW'(1);
                  end
               end
            end
            FLT_FAULT: begin
               if (!invalid_c) begin
                  state_q <= FLT_RECOVER;
                  fcnt_q  <= '0;
               end
            end
            FLT_RECOVER: begin
               if (invalid_c) begin
                  state_q <= FLT_FAULT;
                  fcnt_q  <= '0;
               end else if (tick_q) begin
                  if (fcnt_q == FW'(FAULT_TICKS - 1)) begin
                     state_q       <= FLT_OK;
                     fcnt_q        <= '0;
                     level_fault_q <= 1'b0;
                  end else begin
                     fcnt_q <= fcnt_q + FW'(1);
                  end
               end
            end
            default: begin
               state_q       <= FLT_OK;
               fcnt_q        <= '0;
               level_fault_q <= 1'b0;
            end
         endcase
      end
   end

   assign H           = dout_c[IDX_H];
   assign M           = dout_c[IDX_M];
   assign L           = dout_c[IDX_L];
   assign Us          = dout_c[IDX_US];
   assign Ua          = dout_c[IDX_UA];
   assign T           = dout_c[IDX_T];
   assign tick        = tick_q;
   assign changed     = changed_q;
   assign level_fault = level_fault_q;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed bench for sensor_conditioner with TICK_DIV=4, DEBOUNCE_TICKS=3, FAULT_TICKS=2.
module tb_sensor_conditioner;

   localparam int unsigned TD = 4;
   localparam int unsigned DT = 3;
   localparam int unsigned FT = 2;

   logic clock;
   logic Rst;
   logic H_raw, M_raw, L_raw, Us_raw, Ua_raw, T_raw;
   logic H, M, L, Us, Ua, T;
   logic tick, changed, level_fault;
   logic [5:0] lv;
   logic [8:0] all_o;
   logic       seen;

   int unsigned errors = 0;
   int unsigned checks = 0;

   sensor_conditioner #(
      .TICK_DIV       (TD),
      .DEBOUNCE_TICKS (DT),
      .FAULT_TICKS    (FT)
   ) dut (
      .clock       (clock),
      .Rst         (Rst),
      .H_raw       (H_raw),
      .M_raw       (M_raw),
      .L_raw       (L_raw),
      .Us_raw      (Us_raw),
      .Ua_raw      (Ua_raw),
      .T_raw       (T_raw),
      .H           (H),
      .M           (M),
      .L           (L),
      .Us          (Us),
      .Ua          (Ua),
      .T           (T),
      .tick        (tick),
      .changed     (changed),
      .level_fault (level_fault)
   );

   assign lv    = {H, M, L, Us, Ua, T};
   assign all_o = {H, M, L, Us, Ua, T, tick, changed, level_fault};

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance n rising edges, then settle 1 time unit before sampling or driving.
   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic set_raw(input logic [5:0] v);
      {H_raw, M_raw, L_raw, Us_raw, Ua_raw, T_raw} = v;
   endtask

   // Return two edges before a tick-consuming edge, so a raw change lands for the 14-cycle worst case.
   task automatic align();
      int n;
      n = 0;
      do begin
         step(1);
         n++;
      end while (!tick && n < int'(2 * TD));
      check_eq("align_tick", 32'(tick), 32'(1'b1));
      step(3);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

   initial begin
      // 1: reset with all raw inputs high
      Rst = 1'b1;
      set_raw(6'h3F);
      for (int i = 0; i < 4; i++) begin
         step(1);
         check_eq("rst_hold", 32'(all_o), 32'(9'h000));
      end
      Rst = 1'b0;
      check_eq("rst_first_cycle", 32'(all_o), 32'(9'h000));
      for (int c = 1; c <= 4; c++) begin
         check_eq($sformatf("tick_c%0d", c), 32'(tick), 32'(c == 4));
         if (c < 4) step(1);
      end
      step(8);
      check_eq("all_pre", 32'(lv), 32'(6'h00));
      step(1);
      check_eq("all_set", 32'(lv), 32'(6'h3F));
      check_eq("all_chg0", 32'(changed), 32'(1'b0));
      step(1);
      check_eq("all_chg1", 32'(changed), 32'(1'b1));
      step(1);
      check_eq("all_chg2", 32'(changed), 32'(1'b0));
      check_eq("all_valid_lf", 32'(level_fault), 32'(1'b0));

      // 2: L rise, worst-case alignment
      set_raw(6'h00);
      Rst = 1'b1;
      step(2);
      Rst = 1'b0;
      check_eq("rst2_clear", 32'(all_o), 32'(9'h000));
      align();
      L_raw = 1'b1;
      step(13);
      check_eq("L_pre", 32'(L), 32'(1'b0));
      step(1);
      check_eq("L_set", 32'(L), 32'(1'b1));
      check_eq("L_chg0", 32'(changed), 32'(1'b0));
      step(1);
      check_eq("L_chg1", 32'(changed), 32'(1'b1));
      step(1);
      check_eq("L_chg2", 32'(changed), 32'(1'b0));

      // 3: short Us pulses never get through
      seen = 1'b0;
      for (int p = 0; p < 6; p++) begin
         for (int c = 0; c < 8; c++) begin
            Us_raw = (c < 3);
            step(1);
            seen = seen | Us | changed;
         end
      end
      check_eq("us_glitch", 32'(seen), 32'(1'b0));
      check_eq("us_levels", 32'(lv), 32'(6'b001000));

      // 4: H over dry M -> fault after 2 ticks, recover after 2 valid ticks
      align();
      H_raw = 1'b1;
      step(14);
      check_eq("H_set", 32'(H), 32'(1'b1));
      step(7);
      check_eq("flt_pre", 32'(level_fault), 32'(1'b0));
      step(1);
      check_eq("flt_set", 32'(level_fault), 32'(1'b1));
      align();
      H_raw = 1'b0;
      step(14);
      check_eq("H_clr", 32'(H), 32'(1'b0));
      step(7);
      check_eq("rec_hold", 32'(level_fault), 32'(1'b1));
      step(1);
      check_eq("rec_done", 32'(level_fault), 32'(1'b0));

      // 5: triple becomes valid right after the first counted suspect tick
      align();
      H_raw = 1'b1;
      step(4);
      M_raw = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 30; c++) begin
         step(1);
         seen = seen | level_fault;
      end
      check_eq("sus_abort_lf", 32'(seen), 32'(1'b0));
      check_eq("sus_abort_lvl", 32'({H, M, L}), 32'(3'b111));

      // 6: reset during FAULT with Us mid-debounce
      align();
      M_raw = 1'b0;
      step(21);
      check_eq("f6_pre", 32'(level_fault), 32'(1'b0));
      step(1);
      check_eq("f6_fault", 32'(level_fault), 32'(1'b1));
      align();
      Us_raw = 1'b1;
      step(11);
      check_eq("f6_mid_us", 32'(Us), 32'(1'b0));
      check_eq("f6_mid_lf", 32'(level_fault), 32'(1'b1));
      Rst = 1'b1;
      Us_raw = 1'b0;
      step(1);
      check_eq("f6_rst_clear", 32'(all_o), 32'(9'h000));
      Rst = 1'b0;
      step(11);
      check_eq("f6_rel_pre", 32'(lv), 32'(6'h00));
      step(1);
      check_eq("f6_rel_set", 32'(lv), 32'(6'b101000));
      step(7);
      check_eq("f6_refault_pre", 32'(level_fault), 32'(1'b0));
      step(1);
      check_eq("f6_refault", 32'(level_fault), 32'(1'b1));
      align();
      Us_raw = 1'b1;
      step(13);
      check_eq("f6_us_pre", 32'(Us), 32'(1'b0));
      step(1);
      check_eq("f6_us_set", 32'(Us), 32'(1'b1));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
